// File: rtl/bram_ctrl_pkg.sv
// Shared types for the two-read/one-write BRAM controller.
// FSM state encoding and response FIFO depth.
package bram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int RESP_FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_ctrl_resp_fifo.sv
// Per-port read response FIFO, valid/ready on the pop side.
// Outputs zero data while empty.
module bram_ctrl_resp_fifo
    import bram_ctrl_pkg::*;
#(
    parameter  int W  = 32,
    localparam int PW = $clog2(RESP_FIFO_DEPTH),
    localparam int CW = $clog2(RESP_FIFO_DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [RESP_FIFO_DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_full  = (r_cnt == CW'(RESP_FIFO_DEPTH));
    assign o_valid = (r_cnt != '0);
    assign w_pop   = o_valid & i_ready;
    // a full FIFO still takes a push when the head leaves this cycle
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_data  = o_valid ? r_mem[r_rp] : '0;
    assign o_count = r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/bram_2r1w_ctrl.sv
// Two-read/one-write BRAM controller with power-up clear.
// Define BRAM_CTRL_WR_BYPASS_EN to forward same-cycle write bytes to reads.
module bram_2r1w_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter  int INNER_WIDTH = 32,
    parameter  int OUTER_WIDTH = 32,
    localparam int IW          = $clog2(OUTER_WIDTH),
    localparam int BW          = INNER_WIDTH / 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   rd0_req_valid,
    output logic                   rd0_req_ready,
    input  logic [IW-1:0]          rd0_req_index,
    output logic                   rd0_resp_valid,
    input  logic                   rd0_resp_ready,
    output logic [INNER_WIDTH-1:0] rd0_resp_data,
    input  logic                   rd1_req_valid,
    output logic                   rd1_req_ready,
    input  logic [IW-1:0]          rd1_req_index,
    output logic                   rd1_resp_valid,
    input  logic                   rd1_resp_ready,
    output logic [INNER_WIDTH-1:0] rd1_resp_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [IW-1:0]          wr_index,
    input  logic [BW-1:0]          wr_byte_en,
    input  logic [INNER_WIDTH-1:0] wr_data,
    output logic                   init_done,
    output logic                   port0_ren,
    output logic [IW-1:0]          port0_rindex,
    input  logic [INNER_WIDTH-1:0] port0_rdata,
    output logic                   port1_ren,
    output logic [IW-1:0]          port1_rindex,
    input  logic [INNER_WIDTH-1:0] port1_rdata,
    output logic [BW-1:0]          wen_byte,
    output logic [IW-1:0]          windex,
    output logic [INNER_WIDTH-1:0] wdata
);

    localparam int W  = INNER_WIDTH;
    localparam int CW = $clog2(RESP_FIFO_DEPTH + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_cnt;
    logic          w_init_done;
    logic          w_wr_acc;

    logic [1:0]    w_req_valid;
    logic [1:0]    w_req_ready;
    logic [1:0]    w_acc;
    logic [1:0]    w_resp_valid;
    logic [1:0]    w_resp_ready;
    logic [IW-1:0] w_req_idx    [2];
    logic [W-1:0]  w_port_rdata [2];
    logic [W-1:0]  w_resp_data  [2];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (r_state == INIT) begin
            r_cnt <= r_cnt + IW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init_done = 1'b0;
        wen_byte    = '0;
        windex      = '0;
        wdata       = '0;
        unique case (r_state)
            INIT: begin
                // reset holds the write port quiet even though state is INIT
                if (nRST) begin
                    wen_byte = '1;
                    windex   = r_cnt;
                end
                if (r_cnt == IW'(OUTER_WIDTH - 1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_init_done = 1'b1;
                if (wr_valid) begin
                    wen_byte = wr_byte_en;
                    windex   = wr_index;
                    wdata    = wr_data;
                end
            end
            default: ;
        endcase
    end

    assign init_done = w_init_done;
    assign wr_ready  = w_init_done;
    assign w_wr_acc  = wr_valid & w_init_done;

    assign w_req_valid     = {rd1_req_valid, rd0_req_valid};
    assign w_resp_ready    = {rd1_resp_ready, rd0_resp_ready};
    assign w_req_idx[0]    = rd0_req_index;
    assign w_req_idx[1]    = rd1_req_index;
    assign w_port_rdata[0] = port0_rdata;
    assign w_port_rdata[1] = port1_rdata;

    assign rd0_req_ready  = w_req_ready[0];
    assign rd1_req_ready  = w_req_ready[1];
    assign rd0_resp_valid = w_resp_valid[0];
    assign rd1_resp_valid = w_resp_valid[1];
    assign rd0_resp_data  = w_resp_data[0];
    assign rd1_resp_data  = w_resp_data[1];
    assign port0_ren      = w_acc[0];
    assign port1_ren      = w_acc[1];
    assign port0_rindex   = w_acc[0] ? w_req_idx[0] : '0;
    assign port1_rindex   = w_acc[1] ? w_req_idx[1] : '0;

`ifdef BRAM_CTRL_WR_BYPASS_EN
    logic [W-1:0] w_wr_bits;
    logic [W-1:0] r_byp_data;

    always_comb begin
        w_wr_bits = '0;
        for (int i = 0; i < W; i++) begin
            w_wr_bits[i] = wr_byte_en[i/8];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_byp_data <= '0;
        end else if (w_wr_acc) begin
            r_byp_data <= wr_data;
        end
    end
`endif

    for (genvar g = 0; g < 2; g++) begin : g_rd
        logic          r_inflight;
        logic [CW-1:0] w_cnt;
        logic [W-1:0]  w_push_data;

        // a read in flight already owns a FIFO slot
        assign w_req_ready[g] = w_init_done &
            ((w_cnt + CW'(r_inflight)) < CW'(RESP_FIFO_DEPTH));
        assign w_acc[g] = w_req_valid[g] & w_req_ready[g];

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_acc[g];
            end
        end

`ifdef BRAM_CTRL_WR_BYPASS_EN
        logic [W-1:0] r_byp_bits;

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                r_byp_bits <= '0;
            end else if (w_acc[g] & w_wr_acc &
                         (wr_index == w_req_idx[g])) begin
                r_byp_bits <= w_wr_bits;
            end else begin
                r_byp_bits <= '0;
            end
        end

        assign w_push_data = (w_port_rdata[g] & ~r_byp_bits) |
                             (r_byp_data & r_byp_bits);
`else
        assign w_push_data = w_port_rdata[g];
`endif

        bram_ctrl_resp_fifo #(
            .W (W)
        ) u_fifo (
            .CLK     (CLK),
            .nRST    (nRST),
            .i_push  (r_inflight),
            .i_data  (w_push_data),
            .o_valid (w_resp_valid[g]),
            .i_ready (w_resp_ready[g]),
            .o_data  (w_resp_data[g]),
            .o_count (w_cnt)
        );
    end

endmodule

// File: tb/tb_bram_2r1w_ctrl.sv
// Self-checking bench for bram_2r1w_ctrl with a behavioural BRAM,
// a transaction-level reference model and directed/random stimulus.
module tb_bram_2r1w_ctrl;

    logic            CLK;
    logic            nRST;
    logic [1:0]      rv, rr, rdy, rsv;
    logic [1:0][4:0] ridx;
    logic [1:0][31:0] rdat;
    logic            wv, wr_ready, init_done;
    logic [4:0]      widx;
    logic [3:0]      wbe;
    logic [31:0]     wd;
    logic [1:0]      ren;
    logic [1:0][4:0] rix;
    logic [1:0][31:0] prd;
    logic [3:0]      wen_byte;
    logic [4:0]      windex;
    logic [31:0]     wdata;

    bram_2r1w_ctrl #(
        .INNER_WIDTH (32),
        .OUTER_WIDTH (32)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .rd0_req_valid  (rv[0]),
        .rd0_req_ready  (rdy[0]),
        .rd0_req_index  (ridx[0]),
        .rd0_resp_valid (rsv[0]),
        .rd0_resp_ready (rr[0]),
        .rd0_resp_data  (rdat[0]),
        .rd1_req_valid  (rv[1]),
        .rd1_req_ready  (rdy[1]),
        .rd1_req_index  (ridx[1]),
        .rd1_resp_valid (rsv[1]),
        .rd1_resp_ready (rr[1]),
        .rd1_resp_data  (rdat[1]),
        .wr_valid       (wv),
        .wr_ready       (wr_ready),
        .wr_index       (widx),
        .wr_byte_en     (wbe),
        .wr_data        (wd),
        .init_done      (init_done),
        .port0_ren      (ren[0]),
        .port0_rindex   (rix[0]),
        .port0_rdata    (prd[0]),
        .port1_ren      (ren[1]),
        .port1_rindex   (rix[1]),
        .port1_rdata    (prd[1]),
        .wen_byte       (wen_byte),
        .windex         (windex),
        .wdata          (wdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // behavioural BRAM: read data one cycle after ren, read-before-write
    logic [31:0] bram [32];
    always @(posedge CLK) begin
        for (int p = 0; p < 2; p++) begin
            if (ren[p]) prd[p] <= bram[rix[p]];
        end
        for (int b = 0; b < 4; b++) begin
            if (wen_byte[b]) bram[windex][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic [31:0] d;
        int          cyc;
    } rq_t;

    typedef struct {
        logic [4:0]  idx;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    rq_t         mq [2][2];
    int          mn [2];
    logic [31:0] ref_mem [32];
    bit          m_run;
    int          m_k;
    int          now;
    int          acc_cnt [2];
    int          pop_cnt [2];
    logic [31:0] got [2];
    int          tests;
    int          errors;
    vec_t        vt [8];

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
        end
    endfunction

    function automatic bit vis(int p);
        return (mn[p] > 0) && (mq[p][0].cyc + 2 <= now);
    endfunction

    task automatic check_outputs();
        if (!m_run) begin
            chk("init_wen", wen_byte, 32'hF);
            chk("init_windex", windex, m_k);
            chk("init_wdata", wdata, 0);
            chk("init_done_lo", init_done, 0);
            chk("init_ready_ren", {rdy, wr_ready, ren}, 0);
            chk("init_resp_valid", rsv, 0);
        end else begin
            chk("run_done_ready", {init_done, wr_ready}, 3);
            for (int p = 0; p < 2; p++) begin
                bit er;
                bit v;
                er = (mn[p] < 2);
                v  = vis(p);
                chk($sformatf("rd%0d_req_ready", p), rdy[p], er);
                chk($sformatf("port%0d_ren", p), ren[p], rv[p] && er);
                chk($sformatf("port%0d_rindex", p), rix[p],
                    (rv[p] && er) ? ridx[p] : 5'd0);
                chk($sformatf("rd%0d_resp_valid", p), rsv[p], v);
                chk($sformatf("rd%0d_resp_data", p), rdat[p],
                    v ? mq[p][0].d : 32'd0);
            end
            chk("wen_byte", wen_byte, wv ? wbe : 4'd0);
            chk("windex", windex, wv ? widx : 5'd0);
            chk("wdata", wdata, wv ? wd : 32'd0);
        end
    endtask

    task automatic advance_model();
        logic [31:0] e [2];
        bit          acc [2];
        bit          pop [2];
        if (!m_run) begin
            ref_mem[m_k] = 32'd0;
            m_k++;
            if (m_k == 32) begin
                m_run = 1'b1;
                m_k   = 0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                pop[p] = vis(p) && rr[p];
                acc[p] = rv[p] && (mn[p] < 2);
                e[p]   = ref_mem[ridx[p]];
`ifdef BRAM_CTRL_WR_BYPASS_EN
                if (acc[p] && wv && widx == ridx[p]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wbe[b]) e[p][8*b +: 8] = wd[8*b +: 8];
                    end
                end
`endif
            end
            for (int p = 0; p < 2; p++) begin
                if (pop[p]) begin
                    got[p]   = mq[p][0].d;
                    mq[p][0] = mq[p][1];
                    mn[p]--;
                    pop_cnt[p]++;
                end
                if (acc[p]) begin
                    mq[p][mn[p]] = '{d: e[p], cyc: now};
                    mn[p]++;
                    acc_cnt[p]++;
                end
            end
            if (wv) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbe[b]) ref_mem[widx][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
        now++;
    endtask

    task automatic step();
        @(negedge CLK);
        check_outputs();
        advance_model();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        rv   = 2'b00;
        wv   = 1'b0;
        #1;
        chk("rst_ready", {rdy, wr_ready, init_done}, 0);
        chk("rst_resp_valid", rsv, 0);
        chk("rst_resp_data0", rdat[0], 0);
        chk("rst_resp_data1", rdat[1], 0);
        chk("rst_ren_rindex", {ren, rix}, 0);
        chk("rst_wen_windex", {wen_byte, windex}, 0);
        chk("rst_wdata", wdata, 0);
        mn[0] = 0;
        mn[1] = 0;
        m_run = 1'b0;
        m_k   = 0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic do_write(logic [4:0] i, logic [3:0] be, logic [31:0] d);
        wv   = 1'b1;
        widx = i;
        wbe  = be;
        wd   = d;
        step();
        wv = 1'b0;
    endtask

    task automatic wait_pop(int p, output int n);
        int p0;
        p0 = pop_cnt[p];
        n  = 0;
        rr[p] = 1'b1;
        while (pop_cnt[p] == p0 && n < 10) begin
            step();
            n++;
        end
        if (pop_cnt[p] == p0) chk($sformatf("rd%0d_pop_timeout", p), 0, 1);
    endtask

    task automatic do_read(int p, logic [4:0] i, output logic [31:0] d,
                           output int lat);
        int a0;
        int n;
        a0 = acc_cnt[p];
        rv[p]   = 1'b1;
        ridx[p] = i;
        n = 0;
        while (acc_cnt[p] == a0 && n < 10) begin
            step();
            n++;
        end
        rv[p] = 1'b0;
        if (acc_cnt[p] == a0) chk($sformatf("rd%0d_acc_timeout", p), 0, 1);
        wait_pop(p, lat);
        d = got[p];
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        int          a0;
        int          n;

        tests  = 0;
        errors = 0;
        now    = 0;
        nRST   = 1'b1;
        rv     = 2'b00;
        rr     = 2'b11;
        ridx   = '0;
        wv     = 1'b0;
        widx   = '0;
        wbe    = '0;
        wd     = '0;
        for (int i = 0; i < 2; i++) begin
            mn[i] = 0;
            acc_cnt[i] = 0;
            pop_cnt[i] = 0;
            got[i] = '0;
        end
        for (int i = 0; i < 32; i++) begin
            bram[i]    = $urandom;
            ref_mem[i] = 32'hx;
        end

        vt[0] = '{5'd3,  4'hF, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[1] = '{5'd3,  4'h3, 32'h00001234, 32'hDEAD1234};
        vt[2] = '{5'd3,  4'h8, 32'hAA000000, 32'hAAAD1234};
        vt[3] = '{5'd10, 4'h4, 32'h00550000, 32'h00550000};
        vt[4] = '{5'd31, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[5] = '{5'd31, 4'h2, 32'h00000000, 32'hFFFF00FF};
        vt[6] = '{5'd0,  4'h1, 32'h00000012, 32'h00000012};
        vt[7] = '{5'd0,  4'h6, 32'h89ABCDEF, 32'h00ABCD12};

        #2;
        do_reset();

        // power-up clear
        repeat (32) step();
        chk("init_done_after_32", init_done, 1);
        do_read(0, 5'd5, d, lat);
        chk("rd_idx5_cleared", d, 0);

        // write then read back the next cycle
        for (int i = 0; i < 8; i++) begin
            do_write(vt[i].idx, vt[i].be, vt[i].d);
            do_read(i % 2, vt[i].idx, d, lat);
            chk($sformatf("vec%0d_data", i), d, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, 2);
        end

        // rd1 backpressure: only two reads may be outstanding
        do_write(5'd1, 4'hF, 32'h0101A1A1);
        do_write(5'd2, 4'hF, 32'h0202B2B2);
        do_write(5'd3, 4'hF, 32'h0303C3C3);
        rr[1]   = 1'b0;
        rv[1]   = 1'b1;
        ridx[1] = 5'd1;
        a0 = acc_cnt[1];
        for (int i = 0; i < 8; i++) begin
            n = acc_cnt[1];
            step();
            if (acc_cnt[1] != n) ridx[1] = ridx[1] + 5'd1;
        end
        chk("bp_accepted", acc_cnt[1] - a0, 2);
        chk("bp_req_ready_lo", rdy[1], 0);
        rr[1] = 1'b1;
        step();
        chk("bp_first", got[1], 32'h0101A1A1);
        step();
        chk("bp_second", got[1], 32'h0202B2B2);
        rv[1] = 1'b0;
        chk("bp_third_accepted", acc_cnt[1] - a0, 3);
        wait_pop(1, lat);
        chk("bp_third", got[1], 32'h0303C3C3);

        // same-cycle write and read of one index
        do_write(5'd7, 4'hF, 32'h11223344);
        wv = 1'b1; widx = 5'd7; wbe = 4'h1; wd = 32'h000000AA;
        rv[0] = 1'b1; ridx[0] = 5'd7;
        a0 = acc_cnt[0];
        step();
        wv = 1'b0;
        rv[0] = 1'b0;
        chk("same_cyc_accepted", acc_cnt[0] - a0, 1);
        wait_pop(0, lat);
`ifdef BRAM_CTRL_WR_BYPASS_EN
        chk("same_cyc_data", got[0], 32'h112233AA);
`else
        chk("same_cyc_data", got[0], 32'h11223344);
`endif
        do_read(1, 5'd7, d, lat);
        chk("after_write_data", d, 32'h112233AA);

        // both ports read one index together
        do_write(5'd9, 4'hF, 32'hCAFEF00D);
        rv = 2'b11; ridx[0] = 5'd9; ridx[1] = 5'd9;
        a0 = acc_cnt[0] + acc_cnt[1];
        step();
        rv = 2'b00;
        chk("dual_accepted", acc_cnt[0] + acc_cnt[1] - a0, 2);
        n = pop_cnt[0] + pop_cnt[1];
        for (int i = 0; i < 6 && (pop_cnt[0] + pop_cnt[1] - n) < 2; i++)
            step();
        chk("dual_pops", pop_cnt[0] + pop_cnt[1] - n, 2);
        chk("dual_rd0", got[0], 32'hCAFEF00D);
        chk("dual_rd1", got[1], 32'hCAFEF00D);

        // reset with responses pending
        rr = 2'b00;
        rv = 2'b11; ridx[0] = 5'd9; ridx[1] = 5'd3;
        repeat (4) step();
        rv = 2'b00;
        repeat (2) step();
        chk("pre_rst_pending", rsv, 2'b11);
        do_reset();
        rr = 2'b11;
        repeat (32) step();
        chk("reinit_done", init_done, 1);
        repeat (3) step();

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rv      = 2'($urandom);
            rr      = 2'($urandom | $urandom);
            ridx[0] = ($urandom % 2) ? 5'($urandom_range(0, 3))
                                     : 5'($urandom);
            ridx[1] = ($urandom % 2) ? 5'($urandom_range(0, 3))
                                     : 5'($urandom);
            wv      = 1'($urandom);
            widx    = ($urandom % 2) ? 5'($urandom_range(0, 3))
                                     : 5'($urandom);
            wbe     = 4'($urandom);
            wd      = $urandom;
            step();
        end
        rv = 2'b00;
        wv = 1'b0;
        rr = 2'b11;
        repeat (5) step();
        chk("drained", mn[0] + mn[1], 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/bram_2r1w_ctrl.md
BRAM_2R1W_CTRL -- requirements
Module: bram_2r1w_ctrl

Interface
REQ-001 SHALL have parameter INNER_WIDTH, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter OUTER_WIDTH, default 32, entry count; power of two, at least 2; IW = $clog2(OUTER_WIDTH).
REQ-003 SHALL have port CLK  input  1  clock; all state on posedge CLK.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports rdN_req_valid  input  1  read request valid; N = 0, 1 throughout.
REQ-006 SHALL have ports rdN_req_ready  output  1  read request accepted.
REQ-007 SHALL have ports rdN_req_index  input  IW  read index.
REQ-008 SHALL have ports rdN_resp_valid  output  1  response available.
REQ-009 SHALL have ports rdN_resp_ready  input  1  response consumed.
REQ-010 SHALL have ports rdN_resp_data  output  INNER_WIDTH  response word.
REQ-011 SHALL have ports wr_valid / wr_ready  input / output  1 / 1  write handshake.
REQ-012 SHALL have ports wr_index, wr_byte_en, wr_data  input  IW, INNER_WIDTH/8, INNER_WIDTH  write request.
REQ-013 SHALL have port init_done  output  1  memory clear complete.
REQ-014 SHALL have ports portN_ren, portN_rindex  output  1, IW  BRAM read port drive.
REQ-015 SHALL have ports portN_rdata  input  INNER_WIDTH  BRAM read data, valid the cycle after portN_ren.
REQ-016 SHALL have ports wen_byte, windex, wdata  output  INNER_WIDTH/8, IW, INNER_WIDTH  BRAM write port drive.

Function
REQ-017 SHALL run a two-state FSM: INIT (entered on reset) -> RUN, with no other transitions.
REQ-018 In INIT: SHALL drive wen_byte all-ones, wdata 0, windex = counter; counter runs 0..OUTER_WIDTH-1, then goes to RUN; init takes exactly OUTER_WIDTH cycles.
REQ-019 In INIT: SHALL hold init_done, rdN_req_ready and wr_ready at 0.
REQ-020 In RUN: SHALL hold init_done at 1.
REQ-021 Read accept occurs on rdN_req_valid & rdN_req_ready; SHALL drive portN_ren=1 and portN_rindex=rdN_req_index combinationally in the same cycle; portN_ren=0 otherwise.
REQ-022 SHALL capture portN_rdata the cycle after accept into a 2-entry per-port response FIFO.
REQ-023 Response SHALL become valid no earlier than 2 cycles after accept.
REQ-024 rdN_req_ready SHALL be 1 only in RUN with (FIFO occupancy + in-flight read) < 2, so no response is ever dropped.
REQ-025 rdN_resp_valid SHALL equal FIFO non-empty; pop on valid & ready; per-port order SHALL be preserved.
REQ-026 Simultaneous push and pop on a full FIFO SHALL be legal.
REQ-027 wr_ready SHALL equal init_done; on accept, SHALL drive wen_byte=wr_byte_en, windex, wdata combinationally in the same cycle; wen_byte=0 otherwise.
REQ-028 Ports 0 and 1 SHALL be fully independent; both may read the same index in the same cycle.
REQ-029 Same-cycle read and write to the same index SHALL return old data unless REQ-034 applies.

Reset
REQ-030 On nRST low: FSM=INIT, counter=0, FIFOs emptied, in-flight flags cleared.
REQ-031 On nRST low: every output SHALL be 0, including wen_byte, portN_ren and rdN_resp_valid; rdN_resp_data SHALL be 0 when empty.
REQ-032 Reset mid-operation SHALL discard pending responses and restart INIT after release.

Configuration
REQ-033 Macro BRAM_CTRL_WR_BYPASS_EN SHALL select same-cycle write bypass.
REQ-034 With BRAM_CTRL_WR_BYPASS_EN defined: on a read accepted the same cycle as a write to the same index, the captured response SHALL take wr_data bytes where wr_byte_en is set and BRAM bytes elsewhere.
REQ-035 Without BRAM_CTRL_WR_BYPASS_EN: no bypass logic; old data per REQ-029.

Structure
REQ-036 Package bram_ctrl_pkg SHALL hold the FSM state enum (INIT, RUN) and the response FIFO depth constant (2).
REQ-037 Sub-module bram_ctrl_resp_fifo (2-entry, valid/ready) SHALL be instantiated once per read port.

Verification
REQ-038 Reset release, OUTER_WIDTH=32 -> windex 0..31 with wdata 0 over 32 cycles, then init_done=1; read idx 5 -> 0x00000000.
REQ-039 Write idx 3, 0xDEADBEEF, byte_en 0xF; read rd0 idx 3 next cycle -> rd0_resp_data 0xDEADBEEF, resp_valid 2 cycles after accept.
REQ-040 rd1_resp_ready=0 with continuous requests idx 1,2,3 -> exactly 2 accepted, then rd1_req_ready=0; release -> mem[1], mem[2] in order, then idx 3 accepted.
REQ-041 mem[7]=0x11223344; same cycle write idx 7, byte_en 0x1, data 0x000000AA, and rd0 read idx 7 -> 0x112233AA with macro, 0x11223344 without; later read -> 0x112233AA.
REQ-042 Both ports read idx 9 (0xCAFEF00D) in one cycle -> both responses 0xCAFEF00D.
REQ-043 nRST low with 2 responses pending -> rdN_resp_valid=0 at once, INIT reruns for 32 cycles.
